// File: rtl/apb_seq_pkg.sv
// apb_seq_pkg: shared widths, FSM states and command record for apb_seq_master
package apb_seq_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_STRB_SIZE = 4;
  localparam int DEF_LEN_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RDY, WAIT_LOW, DONE} state_t;
  typedef struct packed {
    logic                      wr;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_STRB_SIZE-1:0]  strb;
    logic [DEF_LEN_WIDTH-1:0]  len;
  } cmd_t;
endpackage

// File: rtl/apb_seq_if.sv
// apb_seq_if: command, bridge and read-return signals of apb_seq_master; APB_SEQ_SLVERR_EN adds br_slverr/err
interface apb_seq_if #(
  parameter int ADDR_WIDTH = apb_seq_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_seq_pkg::DEF_DATA_WIDTH,
  parameter int STRB_SIZE  = apb_seq_pkg::DEF_STRB_SIZE,
  parameter int LEN_WIDTH  = apb_seq_pkg::DEF_LEN_WIDTH
);
  logic                  cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr, address;
  logic [DATA_WIDTH-1:0] cmd_data, data_in, data_out, rd_data;
  logic [STRB_SIZE-1:0]  cmd_strb, strb;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  trnsfr, wr, br_ready, rd_valid, busy, done;
`ifdef APB_SEQ_SLVERR_EN
  logic                  br_slverr, err;
`endif
  modport master (
`ifdef APB_SEQ_SLVERR_EN
    input br_slverr, output err,
`endif
    input cmd_valid, cmd_wr, cmd_addr, cmd_data, cmd_strb, cmd_len, data_out, br_ready,
    output cmd_ready, trnsfr, wr, strb, address, data_in, rd_valid, rd_data, busy, done
  );
  modport slave (
`ifdef APB_SEQ_SLVERR_EN
    output br_slverr, input err,
`endif
    output cmd_valid, cmd_wr, cmd_addr, cmd_data, cmd_strb, cmd_len, data_out, br_ready,
    input cmd_ready, trnsfr, wr, strb, address, data_in, rd_valid, rd_data, busy, done
  );
endinterface

// File: rtl/apb_seq_beat_gen.sv
// apb_seq_beat_gen: per-beat address/data generator and last-beat detect for apb_seq_master
module apb_seq_beat_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  adv,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  last
);
  logic [LEN_WIDTH-1:0] beat, len;
  // address/data_in track base + beat by stepping alongside the counter; wrap is modulo width
  always_ff @(posedge clk) begin
    if (rst) begin
      beat    <= '0;
      len     <= '0;
      address <= '0;
      data_in <= '0;
    end else if (load) begin
      beat    <= '0;
      len     <= cmd_len;
      address <= cmd_addr;
      data_in <= cmd_data;
    end else if (adv) begin
      beat    <= beat + 1'b1;
      address <= address + 1'b1;
      data_in <= data_in + 1'b1;
    end
  end
  assign last = beat == len - 1'b1;
endmodule

// File: rtl/apb_seq_master.sv
// apb_seq_master: expands burst commands into single-beat apb_bridge transfers; APB_SEQ_SLVERR_EN adds slave-error abort
module apb_seq_master import apb_seq_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STRB_SIZE  = DEF_STRB_SIZE,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input logic        clk,
  input logic        rst,
  apb_seq_if.master  bus
);
  state_t state, state_n;
  cmd_t   cmd;
  logic   load, hit, adv, last, stop;
  assign cmd  = '{wr: bus.cmd_wr, addr: bus.cmd_addr, data: bus.cmd_data, strb: bus.cmd_strb, len: bus.cmd_len};
  assign load = state == IDLE && bus.cmd_valid;
  assign hit  = state == WAIT_RDY && bus.br_ready;
`ifdef APB_SEQ_SLVERR_EN
  assign stop = last | bus.err;
`else
  assign stop = last;
`endif
  assign adv  = state == WAIT_LOW && !bus.br_ready && !stop;
  apb_seq_beat_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_beat (
    .clk(clk), .rst(rst), .load(load), .adv(adv),
    .cmd_addr(cmd.addr), .cmd_data(cmd.data), .cmd_len(cmd.len),
    .address(bus.address), .data_in(bus.data_in), .last(last)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = bus.cmd_valid ? (bus.cmd_len == '0 ? DONE : ISSUE) : IDLE;
      ISSUE:    state_n = WAIT_RDY;
      WAIT_RDY: state_n = bus.br_ready ? WAIT_LOW : WAIT_RDY;
      WAIT_LOW: state_n = bus.br_ready ? WAIT_LOW : (stop ? DONE : ISSUE);
      default:  state_n = IDLE;
    endcase
  end
  // status outputs are registered copies of the next-state decode
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cmd_ready <= 1'b1;
      bus.trnsfr    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      bus.wr        <= 1'b0;
      bus.strb      <= '0;
`ifdef APB_SEQ_SLVERR_EN
      bus.err       <= 1'b0;
`endif
    end else begin
      bus.cmd_ready <= state_n == IDLE;
      bus.trnsfr    <= state_n == ISSUE;
      bus.busy      <= state_n inside {ISSUE, WAIT_RDY, WAIT_LOW};
      bus.done      <= state_n == DONE;
      bus.rd_valid  <= hit && !bus.wr;
      if (hit && !bus.wr) bus.rd_data <= bus.data_out;
      if (load) begin
        bus.wr   <= cmd.wr;
        bus.strb <= STRB_SIZE'(cmd.strb);
      end
`ifdef APB_SEQ_SLVERR_EN
      if (load) bus.err <= 1'b0;
      else if (hit && bus.br_slverr) bus.err <= 1'b1;
`endif
    end
  end
endmodule
